// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, legality check and default widths.
// Latency: none (definitions only).
// Backpressure: not applicable.
package alu_pkg;

  localparam int ALU_W   = 64;
  localparam int ALU_OPW = 4;

  localparam logic [ALU_OPW-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_OPW-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_OPW-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_OPW-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_OPW-1:0] ALU_NOR = 4'b1100;

  // Output register occupancy
  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_t;

  // Response side-band fields captured alongside the result
  typedef struct packed {
    logic id;
    logic zero;
    logic err;
  } rsp_meta_t;

  function automatic logic alu_op_legal(input logic [ALU_OPW-1:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR: alu_op_legal = 1'b1;
      default:                                    alu_op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin chooser: lone valid wins, on contention the one not served last wins.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own issue condition.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       gnt_idx,
  output logic       gnt_vld
);

  assign gnt_vld = |valid;
  // On contention favour the requester that did not win the previous accept
  assign gnt_idx = (&valid) ? ~last : valid[1];

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters and registers the result.
// Latency: response valid the cycle after accept; one op per cycle sustained.
// Backpressure: a held response with rsp_ready low stalls both requesters (ready low).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W   = ALU_W,
  parameter int OPW = ALU_OPW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic [OPW-1:0] req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  input  logic [OPW-1:0] req1_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [W-1:0]   alu_result,
  input  logic           alu_zero,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_result,
  output logic           rsp_zero,
  output logic           rsp_err
);

  rsp_state_t state_q, state_d;
  rsp_meta_t  meta_q;
  logic       last_q;
  logic       gnt_idx, gnt_vld, grant;
  logic       can_issue, accept, op_legal;

  rr_pick2 u_pick (
    .valid   ({req1_valid, req0_valid}),
    .last    (last_q),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Grants are suppressed while reset is asserted so the ALU sees zeros
  assign grant      = gnt_vld & rst_n;
  assign rsp_valid  = (state_q == RSP_FULL);
  assign can_issue  = rst_n & (~rsp_valid | rsp_ready);
  assign accept     = grant & can_issue;
  assign req0_ready = accept & ~gnt_idx;
  assign req1_ready = accept & gnt_idx;
  assign op_legal   = alu_op_legal(alu_op);

  assign rsp_id   = meta_q.id;
  assign rsp_zero = meta_q.zero;
  assign rsp_err  = meta_q.err;

  // Steer the winner's operands to the ALU, zeros when nobody is granted
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (grant) begin
      if (gnt_idx) begin
        alu_a  = req1_a;
        alu_b  = req1_b;
        alu_op = req1_op;
      end else begin
        alu_a  = req0_a;
        alu_b  = req0_b;
        alu_op = req0_op;
      end
    end
  end

  // Output register occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RSP_EMPTY;
    else        state_q <= state_d;
  end

  // Fill on accept (including same-cycle drain and refill), empty on a bare drain
  always_comb begin
    state_d = state_q;
    case (state_q)
      RSP_EMPTY: if (accept) state_d = RSP_FULL;
      RSP_FULL: begin
        if (accept)         state_d = RSP_FULL;
        else if (rsp_ready) state_d = RSP_EMPTY;
      end
      default:  state_d = RSP_EMPTY;
    endcase
  end

  // Capture the response and remember who was served; illegal ops report a zero result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      meta_q     <= '0;
      last_q     <= 1'b1;
    end else if (accept) begin
      rsp_result  <= op_legal ? alu_result : '0;
      meta_q.zero <= op_legal ? alu_zero : 1'b1;
      meta_q.err  <= ~op_legal;
      meta_q.id   <= gnt_idx;
      last_q      <= gnt_idx;
    end
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter that shares the single 64-bit combinational ALU between the execute stage (requester 0) and the address/branch-compare helper (requester 1). It accepts one operation per cycle over valid/ready handshakes and picks a winner round-robin when both requesters are valid. It drives the ALU operand/opcode ports from the winner and captures the result in a one-entry output register with backpressure. Illegal opcodes are flagged rather than forwarded as data.

## Interface
- `W`, 64, operand/result width
- `OPW`, 4, opcode width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req0_valid` / `req1_valid`  in  1  request present
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when valid&ready
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  W  operands
- `req0_op` / `req1_op`  in  OPW  opcode: AND=0000, OR=0001, ADD=0010, SUB=0110, NOR=1100
- `alu_a`, `alu_b`  out  W  to ALU
- `alu_op`  out  OPW  to ALU
- `alu_result`  in  W  from ALU, combinational
- `alu_zero`  in  1  from ALU
- `rsp_valid`  out  1  response held
- `rsp_ready`  in  1  consumer takes response when valid&ready
- `rsp_id`  out  1  requester that issued the response
- `rsp_result`  out  W  registered result
- `rsp_zero`  out  1  registered zero flag
- `rsp_err`  out  1  opcode was illegal

## Operation
- Output register states:
  - EMPTY (`rsp_valid=0`)
  - FULL (`rsp_valid=1`)
- `can_issue = !rsp_valid | rsp_ready`. This allows same-cycle drain and refill.
- Grant:
  - Only one valid requester: it wins.
  - Both valid: the requester not equal to `last` wins.
  - Neither valid: no grant.
- `reqN_ready = grant==N & can_issue`. Both are combinational and never high together.
- ALU drive:
  - With a grant: winner's a/b/op.
  - With no grant: zeros and op=0000.
- On accept (any `reqN_valid & reqN_ready`):
  - Register `rsp_result = alu_result`, `rsp_zero = alu_zero`, `rsp_id = N`.
  - Set `rsp_valid = 1`.
  - Update `last = N`.
- Illegal opcode (not one of the five listed):
  - Still accepted and drives the ALU.
  - Registers `rsp_result = 0`, `rsp_zero = 1`, `rsp_err = 1`.
- Legal opcode registers `rsp_err = 0`.
- Response drained (`rsp_valid & rsp_ready`) with no accept: `rsp_valid = 0`. Data fields hold their last values.
- FULL with `rsp_ready=0`: all `reqN_ready = 0` and every response field holds stable.
- `last` changes only on accept. A valid requester that is not granted is not starved: it wins the next contended accept.

## Timing
- Latency: response visible the cycle after accept.
- Throughput: 1 operation per cycle while `rsp_ready=1`.
- Reset (async assert, sync-to-clk release) sets:
  - `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_zero`, `rsp_err` all to 0
  - `last = 1`, so requester 0 wins the first contention
- During reset, `reqN_ready = 0` and the ALU outputs are driven to zero.
- Reset mid-response: the held response is discarded and not replayed.
- Requesters must hold a/b/op stable while valid and not ready. The arbiter does not buffer unaccepted requests.

## Structure
- Shared package `alu_pkg` holds:
  - opcode localparams `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_NOR`
  - function `alu_op_legal(op)`
  - `W` default
- This package is also used by the decoder.
- The ALU is instantiated at the parent level, not inside this block.
- One natural sub-module: `rr_pick2`, a combinational round-robin chooser with inputs valids and `last`, and outputs grant index and grant-valid.

## Test plan
- Single op, back-to-back: req0 ADD a=5, b=7, `rsp_ready=1` → next cycle `rsp_valid=1`, id 0, result 12, zero 0, err 0.
- Contention after reset: both valid (req0 SUB 9-9, req1 OR 0xF0|0x0F) → req0 first (result 0, zero 1), req1 next cycle (result 0xFF). Then both valid again → req0 wins.
- Backpressure: hold `rsp_ready=0` with both valid for 3 cycles → both ready low and the response unchanged. Release → exactly one accept per cycle resumes.
- Illegal op: req1 op 0111 → result 0, zero 1, err 1, id 1. The next legal op clears err.
- Wrap-around: req0 ADD 0xFFFF_FFFF_FFFF_FFFF + 1 → result 0, zero 1.
- Async reset while FULL with `rsp_ready=0` → `rsp_valid` drops immediately without waiting for a clock edge. After release, req0 wins contention.
